key_event_queue: RTL
====================

Name: key_event_queue

Overview:
- Consumer end of the key event stream.
- Captures the one-cycle event pulses and 32-bit event words produced by the key manager: {8'd1, 16'd0, 3'b0, key[4:0]}.
- Replaces the zero field of each event with a 16-bit timestamp and buffers the result in a small FIFO.
- The CPU drains the FIFO through a strobe-based read port and receives a level interrupt while events are pending.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- AW, 3, pointer width; must equal log2(DEPTH).
- TICK_DIV, 50000, clk cycles per timestamp tick (1 ms at 50 MHz); must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ev_valid  in  1  one-cycle event strobe from the key manager irq.
- ev_data  in  32  event word; sampled only when ev_valid=1.
- rd  in  1  one-cycle CPU pop strobe.
- clr  in  1  synchronous flush.
- rdata  out  32  head entry; 0 when the FIFO is empty.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  AW+1  number of stored entries.
- irq_out  out  1  level interrupt; equals ~empty.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous): pointers=0, count=0, empty=1, full=0, rdata=0, irq_out=0, overflow=0, prescaler=0, ts=0.
- Timestamp:
  - Prescaler counts 0..TICK_DIV-1 on every clk.
  - ts increments in the cycle the prescaler wraps from TICK_DIV-1 to 0.
  - ts wraps from 16'hFFFF to 0.
  - clr does not affect the prescaler or ts.
- Event acceptance: an event is valid when ev_valid=1 and ev_data[31:24]==8'd1.
  - Any other type byte is ignored: no write, no flag change.
- Stored word: {ev_data[31:24], ts_at_capture[15:0], ev_data[7:0]}.
  - ts_at_capture is the ts register value in the ev_valid cycle, before any increment in that same cycle.
- Write: a valid event while not full stores the word at wptr; wptr, count and flags update at the next edge.
- Write latency: empty drops and rdata shows the entry one cycle after ev_valid.
- rdata: combinational read of mem[rptr], gated to 0 when empty.
- Read: rd=1 while not empty advances rptr and decrements count at the edge.
  - The next entry (or 0) appears the following cycle.
  - rd while empty is ignored.
- Simultaneous read and write:
  - Not empty and not full: both happen and count is unchanged.
  - Empty: only the write happens; rd is ignored.
  - Full: the pop and the write both happen; count stays DEPTH; overflow does not set.
- Overflow: a valid event while full without an accompanying rd drops the event.
  - Contents are unchanged and overflow is set to 1.
  - overflow stays 1 until clr or rst.
- clr:
  - Takes priority over rd and ev_valid in the same cycle; that event is discarded.
  - Next cycle: pointers=0, count=0, empty=1, overflow=0.
  - Memory contents are don't-care.
- Flags:
  - empty = (count==0).
  - full = (count==DEPTH).
  - Both are derived from the registered count, so they are never both 1.
  - Pointers are AW bits and wrap naturally.

Test Plan (TICK_DIV=4 unless stated):
- Reset, then one idle cycle: empty=1, irq_out=0, rdata=0, count=0, overflow=0.
- Single event after 12 clk from reset release, with ev_data=32'h0100_0004: next cycle rdata=32'h0100_0304 (ts=3), irq_out=1, count=1. Then rd pulse: one cycle later empty=1, rdata=0.
- Nine valid events with keys 1..9 and no reads: count=8, full=1, overflow=1. Eight reads return keys 1..8 in order with non-decreasing timestamps; after the eighth, empty=1.
- With the FIFO full, pulse rd and ev_valid together (key 5'h10): count stays 8, overflow stays 0. The last entry read out has key 5'h10.
- ev_data=32'h0200_0001 with ev_valid: no write, count=0, empty stays 1.
- Timestamp wrap with TICK_DIV=2: force ts=16'hFFFF, wait 2 clk, send an event; the stored ts field is 0.
- clr asserted in the same cycle as ev_valid with 3 entries and overflow=1: next cycle count=0, empty=1, overflow=0, and that event is absent.

Source files
------------

// File: rtl/key_event_queue.sv
`timescale 1ns/1ps
// key_event_queue
// Consumer end of the key event stream. Valid key events (type byte 8'd1)
// are stamped with a free-running 16-bit timestamp and buffered in a FIFO
// that the CPU drains through a strobe-based read port.
//
// Ports:
//   clk       system clock
//   rst       asynchronous, active-high reset
//   ev_valid  one-cycle event strobe from the key manager
//   ev_data   32-bit event word, sampled when ev_valid=1
//   rd        one-cycle CPU pop strobe
//   clr       synchronous flush (priority over rd and ev_valid)
//   rdata     head entry, 0 when empty
//   empty     FIFO holds no entries
//   full      FIFO holds DEPTH entries
//   count     number of stored entries
//   irq_out   level interrupt while events are pending
//   overflow  sticky: an event was dropped because the FIFO was full
module key_event_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ev_valid,
  input  logic [31:0]   ev_data,
  input  logic          rd,
  input  logic          clr,
  output logic [31:0]   rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          irq_out,
  output logic          overflow
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW       = AW + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [7:0]    EV_TYPE_KEY = 8'd1;

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   ts_q, ts_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_q [DEPTH];

  logic          tick;
  logic          ev_ok;
  logic          do_rd;
  logic          do_wr;
  logic          empty_int;
  logic          full_int;
  logic [31:0]   wr_word;

  // Flags come straight from the registered count.
  assign empty_int = (count_q == '0);
  assign full_int  = (count_q == CNT_FULL);

  // Timestamp prescaler and counter; unaffected by clr.
  always_comb begin
    tick  = (pre_q == PRE_MAX);
    pre_d = tick ? '0 : pre_q + PW'(1);
    ts_d  = tick ? ts_q + 16'd1 : ts_q;
  end

  // FIFO control: clr wins; a pop frees the slot a full-FIFO write needs.
  always_comb begin
    ev_ok   = ev_valid && (ev_data[31:24] == EV_TYPE_KEY);
    do_rd   = rd && !empty_int;
    do_wr   = ev_ok && (!full_int || do_rd);
    wr_word = {ev_data[31:24], ts_q, ev_data[7:0]};

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (do_wr) wptr_d = wptr_q + AW'(1);
      if (do_rd) rptr_d = rptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (ev_ok && full_int && !do_rd) ovf_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      ts_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      ts_q    <= ts_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem_q[wptr_q] <= wr_word;
  end

  assign rdata    = empty_int ? 32'd0 : mem_q[rptr_q];
  assign empty    = empty_int;
  assign full     = full_int;
  assign count    = count_q;
  assign irq_out  = !empty_int;
  assign overflow = ovf_q;

endmodule
